axis_flow_meter: RTL and testbench
==================================

// Module: axis_flow_meter
// PURPOSE
//  Downstream stage of the packet queue: consumes its AXI-Stream output (data/last/mty) and forwards it unchanged
//  through a 2-entry skid buffer, while measuring flow speed. Counts accepted packets and valid bytes over a fixed
//  window of C_WINDOW_CYCLES clocks and publishes per-window totals with a one-cycle strobe for the rate monitor.
// PARAMETERS
//  C_DATA_WIDTH    8     tdata width in bits; multiple of 8; BYTES = C_DATA_WIDTH/8
//  C_MTY_WIDTH     8     tuser_mty width; mty = number of empty (invalid) bytes on a tlast beat
//  C_CNT_WIDTH     32    width of byte/packet accumulators and stat outputs
//  C_WINDOW_CYCLES 1024  measurement window length in clocks; >= 2
// PORTS
//  aclk              in   1             clock; all logic on rising edge
//  areset            in   1             synchronous, active-high reset
//  s_axis_tvalid     in   1             input beat valid (from queue)
//  s_axis_tdata      in   C_DATA_WIDTH  input data
//  s_axis_tlast      in   1             last beat of packet
//  s_axis_tuser_mty  in   C_MTY_WIDTH   empty bytes on last beat
//  s_axis_tready     out  1             registered; high when skid buffer has >= 1 free entry
//  m_axis_tvalid     out  1             output beat valid
//  m_axis_tdata      out  C_DATA_WIDTH  output data
//  m_axis_tlast      out  1             output last
//  m_axis_tuser_mty  out  C_MTY_WIDTH   output mty
//  m_axis_tready     in   1             downstream ready
//  stat_valid        out  1             one-cycle pulse: window closed, stat_* updated
//  stat_pkt_cnt      out  C_CNT_WIDTH   packets (tlast beats) accepted in last closed window
//  stat_byte_cnt     out  C_CNT_WIDTH   valid bytes accepted in last closed window
//  stat_in_pkt       out  1             high while a packet is open (first beat accepted, tlast not yet)
// BEHAVIOUR
//  Reset: s_axis_tready=0 during reset, 1 the first cycle after; m_axis_tvalid/tdata/tlast/tuser_mty=0;
//   stat_valid=0, stat_pkt_cnt=0, stat_byte_cnt=0, stat_in_pkt=0; window counter and accumulators=0; buffer empty.
//  Reset mid-packet discards buffered beats and the open window; no stat_valid is emitted for it.
//  Handshake: accept = s_axis_tvalid & s_axis_tready; emit = m_axis_tvalid & m_axis_tready.
//   m_axis_* registered, latency 1 cycle from accept to m_axis_tvalid when buffer empty.
//   Full throughput: 1 beat/cycle sustained while m_axis_tready=1. m_axis_* held stable while tvalid & !tready.
//   Buffer occupancy 0..2; s_axis_tready = (occ_next < 2) registered so a beat arriving on the cycle ready
//   falls is still stored (skid slot). Order strictly preserved; no beat dropped, duplicated or altered.
//  Byte accounting per accepted beat: non-last -> BYTES; last -> BYTES - mty if mty < BYTES, else 0.
//  Packet accounting: +1 per accepted tlast beat. stat_in_pkt set on accepted non-last beat, cleared on
//   accepted tlast beat (single-beat packet leaves it 0).
//  Window: counter 0..C_WINDOW_CYCLES-1, increments every cycle after reset, wraps to 0.
//   Cycle with counter == C_WINDOW_CYCLES-1: stat_pkt_cnt/stat_byte_cnt <= accumulators + that cycle's beat
//   contribution; stat_valid=1 on the following cycle (aligned with updated stat_*); accumulators <= 0.
//   Beat accepted on the closing cycle belongs to the closing window, never to the next.
//   Accumulators saturate at 2^C_CNT_WIDTH-1 (no wrap); saturation cleared only at window close.
//  Counting is on the input side only; output backpressure does not change totals, only when beats flow.
// TESTING
//  1 Reset held 3 cycles, tvalid=1 -> no accept, all outputs 0; cycle after release s_axis_tready=1.
//  2 DATA=8, WINDOW=16: 4-beat pkt (0x11..0x44, mty=0), tready=1 -> m_axis beats identical, 1-cycle latency;
//    stat_valid at cycle 16 with pkt_cnt=1, byte_cnt=4.
//  3 m_axis_tready=0 for 5 cycles during 10-beat stream -> s_axis_tready drops after 2 buffered, no loss/reorder,
//    m_axis_* stable while stalled; totals pkt=1, bytes=10.
//  4 DATA=32: tlast beats with mty=1 -> +3 bytes, mty=4 -> +0, mty=7 -> +0; non-last -> +4.
//  5 Single-beat tlast accepted exactly at counter=WINDOW-1 -> counted in closing window; next window reports 0.
//  6 CNT_WIDTH=4, 20 beats in one window -> stat_byte_cnt=15 (saturated); next idle window reports 0.

Source files
------------

// File: rtl/axis_flow_meter_if.sv
// AXI-Stream bundle carrying data, last and an empty-byte count on the last beat.
interface axis_flow_meter_if #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_MTY_WIDTH  = 8
);
    logic                    tvalid;
    logic                    tready;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic                    tlast;
    logic [C_MTY_WIDTH-1:0]  tuser_mty;

    modport master (output tvalid, tdata, tlast, tuser_mty, input  tready);
    modport slave  (input  tvalid, tdata, tlast, tuser_mty, output tready);
endinterface

// File: rtl/axis_flow_meter.sv
// Pass-through AXI-Stream stage with a 2-entry skid buffer and a windowed
// packet/byte rate meter on the input side.
module axis_flow_meter #(
    parameter int C_DATA_WIDTH    = 8,
    parameter int C_MTY_WIDTH     = 8,
    parameter int C_CNT_WIDTH     = 32,
    parameter int C_WINDOW_CYCLES = 1024
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_flow_meter_if.slave       s_axis,
    axis_flow_meter_if.master      m_axis,
    output logic                   stat_valid,
    output logic [C_CNT_WIDTH-1:0] stat_pkt_cnt,
    output logic [C_CNT_WIDTH-1:0] stat_byte_cnt,
    output logic                   stat_in_pkt
);
    localparam int                     BYTES    = C_DATA_WIDTH / 8;
    localparam int                     WIN_W    = (C_WINDOW_CYCLES > 2) ? $clog2(C_WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(C_WINDOW_CYCLES - 1);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [C_DATA_WIDTH-1:0] data;
        logic                    last;
        logic [C_MTY_WIDTH-1:0]  mty;
    } beat_t;

    // ------------------------------------------------------------------
    // Skid buffer: out_q drives m_axis, skid_q catches the beat that lands
    // on the cycle the registered ready falls.
    // ------------------------------------------------------------------
    beat_t in_beat;
    beat_t out_q, out_d, skid_q, skid_d;
    logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic  rdy_q, rdy_d;
    logic  accept, drain;

    assign in_beat = '{data: s_axis.tdata, last: s_axis.tlast, mty: s_axis.tuser_mty};
    assign accept  = s_axis.tvalid & rdy_q;
    // Output register can take a new beat when empty or being consumed.
    assign drain   = ~out_vld_q | m_axis.tready;

    // Next-state of the two buffer slots; skid always feeds the output first to keep order.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (drain) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
                if (accept) begin
                    skid_d     = in_beat;
                    skid_vld_d = 1'b1;
                end
            end else if (accept) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
        rdy_d = ~(out_vld_d & skid_vld_d);
    end

    // Buffer registers; ready is held low while in reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_axis.tready    = rdy_q;
    assign m_axis.tvalid    = out_vld_q;
    assign m_axis.tdata     = out_q.data;
    assign m_axis.tlast     = out_q.last;
    assign m_axis.tuser_mty = out_q.mty;

    // ------------------------------------------------------------------
    // Rate meter
    // ------------------------------------------------------------------
    logic [WIN_W-1:0]       win_q;
    logic [C_CNT_WIDTH-1:0] byte_acc_q, pkt_acc_q;
    logic [C_CNT_WIDTH-1:0] stat_byte_q, stat_pkt_q;
    logic                   stat_vld_q, in_pkt_q;
    logic [C_CNT_WIDTH-1:0] beat_bytes, beat_pkts;
    logic [C_CNT_WIDTH:0]   byte_sum, pkt_sum;
    logic [C_CNT_WIDTH-1:0] byte_next, pkt_next;
    logic [31:0]            mty_ext;
    logic                   win_close;

    assign mty_ext   = 32'(s_axis.tuser_mty);
    assign win_close = (win_q == WIN_LAST);

    // Byte/packet contribution of this cycle's accepted beat, folded into saturating sums.
    always_comb begin
        beat_bytes = '0;
        beat_pkts  = '0;
        if (accept) begin
            if (!s_axis.tlast) begin
                beat_bytes = C_CNT_WIDTH'(BYTES);
            end else begin
                beat_pkts = C_CNT_WIDTH'(1);
                if (mty_ext < 32'(BYTES)) beat_bytes = C_CNT_WIDTH'(32'(BYTES) - mty_ext);
            end
        end
        byte_sum  = {1'b0, byte_acc_q} + {1'b0, beat_bytes};
        pkt_sum   = {1'b0, pkt_acc_q} + {1'b0, beat_pkts};
        byte_next = byte_sum[C_CNT_WIDTH] ? CNT_MAX : byte_sum[C_CNT_WIDTH-1:0];
        pkt_next  = pkt_sum[C_CNT_WIDTH]  ? CNT_MAX : pkt_sum[C_CNT_WIDTH-1:0];
    end

    // Window counter, accumulators and published totals; the closing cycle's beat stays in the closing window.
    always_ff @(posedge aclk) begin
        if (areset) begin
            win_q       <= '0;
            byte_acc_q  <= '0;
            pkt_acc_q   <= '0;
            stat_byte_q <= '0;
            stat_pkt_q  <= '0;
            stat_vld_q  <= 1'b0;
            in_pkt_q    <= 1'b0;
        end else begin
            win_q      <= win_close ? '0 : win_q + WIN_W'(1);
            stat_vld_q <= win_close;
            if (win_close) begin
                stat_byte_q <= byte_next;
                stat_pkt_q  <= pkt_next;
                byte_acc_q  <= '0;
                pkt_acc_q   <= '0;
            end else begin
                byte_acc_q <= byte_next;
                pkt_acc_q  <= pkt_next;
            end
            if (accept) in_pkt_q <= ~s_axis.tlast;
        end
    end

    assign stat_valid    = stat_vld_q;
    assign stat_pkt_cnt  = stat_pkt_q;
    assign stat_byte_cnt = stat_byte_q;
    assign stat_in_pkt   = in_pkt_q;
endmodule

// File: tb/tb_axis_flow_meter.sv
// Randomized bench for axis_flow_meter: scoreboard for the stream path,
// per-window byte/packet totals computed from accepted beats.
module tb_axis_flow_meter;
    localparam int DW = 32, MW = 8, CW = 6, WIN = 32, BYTES = DW / 8;
    localparam longint SATMAX = (64'd1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          stat_valid, stat_in_pkt;
    logic [CW-1:0] stat_pkt_cnt, stat_byte_cnt;

    axis_flow_meter_if #(.C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW)) s_if ();
    axis_flow_meter_if #(.C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW)) m_if ();

    axis_flow_meter #(
        .C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW), .C_CNT_WIDTH(CW), .C_WINDOW_CYCLES(WIN)
    ) dut (
        .aclk(aclk), .areset(areset), .s_axis(s_if.slave), .m_axis(m_if.master),
        .stat_valid(stat_valid), .stat_pkt_cnt(stat_pkt_cnt),
        .stat_byte_cnt(stat_byte_cnt), .stat_in_pkt(stat_in_pkt)
    );

    always #5 aclk = ~aclk;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [MW-1:0] m;
    } beat_t;

    beat_t  q[$];
    longint cyc, acc_b, acc_p, exp_pkt, exp_byte;
    logic   exp_sv, exp_inpkt;
    int     vprob, rprob;

    function automatic longint sat(input longint v);
        return (v > SATMAX) ? SATMAX : v;
    endfunction

    task automatic new_beat();
        s_if.tdata     = $urandom;
        s_if.tlast     = ($urandom_range(0, 3) == 0);
        s_if.tuser_mty = 8'($urandom_range(0, 7));
    endtask

    task automatic clear_model();
        q.delete();
        cyc = 0; acc_b = 0; acc_p = 0; exp_pkt = 0; exp_byte = 0;
        exp_sv = 1'b0; exp_inpkt = 1'b0;
    endtask

    // Called just after a posedge: holds reset for 3 edges with traffic offered.
    task automatic do_reset();
        areset = 1'b1;
        s_if.tvalid = 1'b1;
        new_beat();
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_m_mty", m_if.tuser_mty, 0);
        chk("rst_stat_valid", stat_valid, 0);
        chk("rst_stat_pkt", stat_pkt_cnt, 0);
        chk("rst_stat_byte", stat_byte_cnt, 0);
        chk("rst_in_pkt", stat_in_pkt, 0);
        areset = 1'b0;
        clear_model();
        @(posedge aclk);
        #1;
        cyc = 1;
        @(negedge aclk);
        chk("rdy_after_rst", s_if.tready, 1);
    endtask

    // One cycle: check at negedge, update model for the coming edge, drive new inputs.
    task automatic step();
        logic hs_in, hs_out;
        longint c;
        chk("s_tready", s_if.tready, (q.size() < 2));
        chk("m_tvalid", m_if.tvalid, (q.size() != 0));
        if (q.size() != 0 && m_if.tvalid) begin
            chk("m_tdata", m_if.tdata, q[0].d);
            chk("m_tlast", m_if.tlast, q[0].l);
            chk("m_mty", m_if.tuser_mty, q[0].m);
        end
        chk("stat_valid", stat_valid, exp_sv);
        chk("stat_pkt", stat_pkt_cnt, exp_pkt);
        chk("stat_byte", stat_byte_cnt, exp_byte);
        chk("in_pkt", stat_in_pkt, exp_inpkt);

        hs_in  = s_if.tvalid & s_if.tready;
        hs_out = m_if.tvalid & m_if.tready;
        if (hs_out && q.size() != 0) void'(q.pop_front());
        if (hs_in) begin
            q.push_back('{d: s_if.tdata, l: s_if.tlast, m: s_if.tuser_mty});
            if (!s_if.tlast) c = BYTES;
            else c = (s_if.tuser_mty < BYTES) ? BYTES - longint'(s_if.tuser_mty) : 0;
            acc_b += c;
            if (s_if.tlast) acc_p++;
            exp_inpkt = !s_if.tlast;
        end
        exp_sv = 1'b0;
        if (cyc % WIN == WIN - 1) begin
            exp_pkt  = sat(acc_p);
            exp_byte = sat(acc_b);
            exp_sv   = 1'b1;
            acc_b = 0;
            acc_p = 0;
        end
        cyc++;

        @(posedge aclk);
        #1;
        if (hs_in || !s_if.tvalid) begin
            s_if.tvalid = ($urandom_range(0, 99) < vprob);
            new_beat();
        end
        m_if.tready = ($urandom_range(0, 99) < rprob);
        @(negedge aclk);
    endtask

    int vtab[6] = '{100, 100, 70, 30, 0, 100};
    int rtab[6] = '{100, 0, 50, 100, 100, 90};

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        s_if.tuser_mty = '0;
        m_if.tready = 1'b1;
        vprob = 100;
        rprob = 100;
        @(posedge aclk);
        #1;
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int k;
            k = $urandom_range(0, 5);
            vprob = vtab[k];
            rprob = rtab[k];
            if (seg == 20) begin
                @(posedge aclk);
                #1;
                do_reset();
            end
            if (k == 4) repeat (2 * WIN + 5) step();
            else repeat ($urandom_range(5, 120)) step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
